// File: rtl/ts_packet_scheduler.sv
// Round-robin scheduler for four per-tuner TS packet buffers, with optional null-packet stuffing.
// Emits one registered byte stream (valid/sync) toward the output FIFO.
module ts_packet_scheduler #(
  parameter int unsigned PKT_LEN = 188,
  parameter int unsigned SRC_LAT = 2,
  parameter int unsigned GAP     = 2
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [3:0]  GOT_FULL_PACKET,
  input  logic [7:0]  DATA_IN_0,
  input  logic [7:0]  DATA_IN_1,
  input  logic [7:0]  DATA_IN_2,
  input  logic [7:0]  DATA_IN_3,
  input  logic [3:0]  CH_ENABLE,
  input  logic        NULL_EN,
  output logic [3:0]  GIVE_ME_ONE_PACKET,
  output logic [7:0]  DATA_OUT,
  output logic        D_VALID_OUT,
  output logic        P_SYNC_OUT,
  output logic [1:0]  CUR_CH,
  output logic        NULL_ACTIVE,
  output logic [15:0] PKT_CNT
);

  localparam logic [7:0] PKT_LAST  = 8'(PKT_LEN - 1);
  localparam logic [7:0] WAIT_LAST = 8'((SRC_LAT >= 2) ? SRC_LAT - 2 : 0);
  localparam logic [7:0] GAP_LAST  = 8'((GAP >= 1) ? GAP - 1 : 0);
  localparam bit         HAS_WAIT  = (SRC_LAT >= 2);
  localparam bit         HAS_GAP   = (GAP >= 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_XFER  = 3'd3,
    S_NULL  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  give_q, give_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sync_q, sync_d;
  logic        null_q, null_d;
  logic [15:0] pcnt_q, pcnt_d;

  logic [3:0]  elig;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [7:0]  src_byte;
  logic [7:0]  null_byte;

  // Round-robin search: smallest offset from the pointer wins.
  always_comb begin
    elig  = GOT_FULL_PACKET & CH_ENABLE;
    found = 1'b0;
    pick  = ptr_q;
    idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    src_byte = DATA_IN_0;
    case (ch_q)
      2'd0:    src_byte = DATA_IN_0;
      2'd1:    src_byte = DATA_IN_1;
      2'd2:    src_byte = DATA_IN_2;
      default: src_byte = DATA_IN_3;
    endcase
  end

  // Null packet: PID 0x1FFF header, payload all 0xFF.
  always_comb begin
    null_byte = 8'hFF;
    case (cnt_q)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    give_d  = 4'd0;
    data_d  = data_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    null_d  = 1'b0;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (found) begin
          ch_d    = pick;
          give_d  = 4'b0001 << pick;
          state_d = S_REQ;
        end else if (NULL_EN) begin
          state_d = S_NULL;
        end
      end
      S_REQ: begin
        ptr_d   = ch_q + 2'd1;
        cnt_d   = 8'd0;
        state_d = HAS_WAIT ? S_WAIT : S_XFER;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_XFER, S_NULL: begin
        data_d  = (state_q == S_NULL) ? null_byte : src_byte;
        valid_d = 1'b1;
        sync_d  = (cnt_q == 8'd0);
        null_d  = (state_q == S_NULL);
        if (cnt_q == PKT_LAST) begin
          cnt_d   = 8'd0;
          pcnt_d  = pcnt_q + 16'd1;
          state_d = HAS_GAP ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 2'd0;
      ch_q    <= 2'd0;
      give_q  <= 4'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      null_q  <= 1'b0;
      pcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      give_q  <= give_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      null_q  <= null_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign GIVE_ME_ONE_PACKET = give_q;
  assign DATA_OUT           = data_q;
  assign D_VALID_OUT        = valid_q;
  assign P_SYNC_OUT         = sync_q;
  assign CUR_CH             = ch_q;
  assign NULL_ACTIVE        = null_q;
  assign PKT_CNT            = pcnt_q;

endmodule
